alu_muldiv: RTL and testbench

Parametrised execute-stage arithmetic unit replacing the single-operation logic ALU. Single-cycle logic, arithmetic, compare and shift ops produce a combinational result in the same cycle. A single-cycle full-width multiplier and an iterative restoring divider write architectural HI/LO registers. Division stalls the pipeline through a stall/flush handshake with the hazard unit.

---
 rtl/alu_muldiv.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// alu_muldiv: execute-stage arithmetic unit.
// Combinational logic/arithmetic/compare/shift ops, a single-cycle full-width
// multiplier writing HI/LO, and an iterative restoring divider that stalls the
// pipeline while it runs and writes HI/LO when it finishes.
module alu_muldiv #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [4:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] result_o,
    output logic              overflow_o,
    output logic              stall_o
);

    localparam int SHW = $clog2(DATA_W);
    localparam int CW  = SHW + 1;
    localparam int MSB = DATA_W - 1;

    localparam logic [4:0] OP_OR    = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_XOR   = 5'd3;
    localparam logic [4:0] OP_NOR   = 5'd4;
    localparam logic [4:0] OP_ADD   = 5'd5;
    localparam logic [4:0] OP_ADDU  = 5'd6;
    localparam logic [4:0] OP_SUB   = 5'd7;
    localparam logic [4:0] OP_SUBU  = 5'd8;
    localparam logic [4:0] OP_SLT   = 5'd9;
    localparam logic [4:0] OP_SLTU  = 5'd10;
    localparam logic [4:0] OP_SLL   = 5'd11;
    localparam logic [4:0] OP_SRL   = 5'd12;
    localparam logic [4:0] OP_SRA   = 5'd13;
    localparam logic [4:0] OP_LUI   = 5'd14;
    localparam logic [4:0] OP_MULT  = 5'd15;
    localparam logic [4:0] OP_MULTU = 5'd16;
    localparam logic [4:0] OP_DIV   = 5'd17;
    localparam logic [4:0] OP_DIVU  = 5'd18;
    localparam logic [4:0] OP_MFHI  = 5'd19;
    localparam logic [4:0] OP_MFLO  = 5'd20;
    localparam logic [4:0] OP_MTHI  = 5'd21;
    localparam logic [4:0] OP_MTLO  = 5'd22;

    localparam logic [DATA_W-1:0] ZERO     = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] ONES     = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] ONE      = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]     CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]     CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]     CNT_FULL = CW'(DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    // Two's-complement negate; used for magnitudes and the signed fix-up.
    function automatic logic [DATA_W-1:0] neg(input logic [DATA_W-1:0] v);
        return (~v) + ONE;
    endfunction

    // Magnitude of a signed operand (most-negative value maps to itself, read unsigned).
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
        return v[MSB] ? neg(v) : v;
    endfunction

    // ------------------------------------------------------------------
    // Architectural and divider state
    // ------------------------------------------------------------------
    div_state_t        state_r, state_n;
    logic [DATA_W-1:0] hi_r, lo_r;
    logic [CW-1:0]     cnt_r;
    logic [DATA_W-1:0] dvs_r;      // latched divisor magnitude
    logic [DATA_W-1:0] rem_r;      // partial remainder
    logic [DATA_W-1:0] quo_r;      // dividend bits shifting out, quotient bits shifting in
    logic              neg_q_r;    // negate quotient at completion
    logic              neg_r_r;    // negate remainder at completion

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]   sum_s, dif_s, res_s;
    logic                ovf_s;
    logic [SHW-1:0]      shamt_s;
    logic signed [DATA_W-1:0] b_sgn_s;
    logic [2*DATA_W-1:0] a_ext_s, b_ext_s, prod_s;
    logic                is_div_s, is_signed_div_s;

    assign sum_s   = a_i + b_i;
    assign dif_s   = a_i - b_i;
    assign shamt_s = a_i[SHW-1:0];
    assign b_sgn_s = b_i;

    assign is_div_s        = (op_i == OP_DIV) || (op_i == OP_DIVU);
    assign is_signed_div_s = (op_i == OP_DIV);

    // MULT sign-extends both operands to double width; the truncated product is then exact.
    assign a_ext_s = (op_i == OP_MULT) ? {{DATA_W{a_i[MSB]}}, a_i} : {ZERO, a_i};
    assign b_ext_s = (op_i == OP_MULT) ? {{DATA_W{b_i[MSB]}}, b_i} : {ZERO, b_i};
    assign prod_s  = a_ext_s * b_ext_s;

    // Select the single-cycle result and signed-overflow flag for the current op.
    always_comb begin
        res_s = ZERO;
        ovf_s = 1'b0;
        case (op_i)
            OP_OR:   res_s = a_i | b_i;
            OP_AND:  res_s = a_i & b_i;
            OP_XOR:  res_s = a_i ^ b_i;
            OP_NOR:  res_s = ~(a_i | b_i);
            OP_ADD: begin
                res_s = sum_s;
                ovf_s = (a_i[MSB] == b_i[MSB]) && (sum_s[MSB] != a_i[MSB]);
            end
            OP_ADDU: res_s = sum_s;
            OP_SUB: begin
                res_s = dif_s;
                ovf_s = (a_i[MSB] != b_i[MSB]) && (dif_s[MSB] != a_i[MSB]);
            end
            OP_SUBU: res_s = dif_s;
            OP_SLT:  res_s = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_SLTU: res_s = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
            OP_SLL:  res_s = b_i << shamt_s;
            OP_SRL:  res_s = b_i >> shamt_s;
            OP_SRA:  res_s = $unsigned(b_sgn_s >>> shamt_s);
            OP_LUI:  res_s = b_i << (DATA_W / 2);
            OP_MFHI: res_s = hi_r;
            OP_MFLO: res_s = lo_r;
            default: begin
                res_s = ZERO;
                ovf_s = 1'b0;
            end
        endcase
    end

    assign result_o   = (rst_i || !valid_i) ? ZERO : res_s;
    assign overflow_o = (rst_i || !valid_i) ? 1'b0 : ovf_s;

    // ------------------------------------------------------------------
    // Divider control
    // ------------------------------------------------------------------
    logic stall_s, accept_s, done_wr_s;

    // Divider next state, stall request and accept/complete strobes.
    always_comb begin
        state_n   = state_r;
        stall_s   = 1'b0;
        accept_s  = 1'b0;
        done_wr_s = 1'b0;
        if (rst_i) begin
            state_n = ST_IDLE;
        end else if (flush_i) begin
            state_n = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (valid_i && is_div_s) begin
                        accept_s = 1'b1;
                        stall_s  = 1'b1;
                        state_n  = (b_i == ZERO) ? ST_DONE : ST_BUSY;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    stall_s = 1'b1;
                    if (cnt_r == CNT_ONE) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_BUSY;
                    end
                end
                ST_DONE: begin
                    done_wr_s = 1'b1;
                    state_n   = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign stall_o = stall_s;

    // Divider state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // ------------------------------------------------------------------
    // Restoring divide step
    // ------------------------------------------------------------------
    logic [DATA_W:0]   shifted_s, trial_s;
    logic [DATA_W-1:0] rem_step_s, quo_step_s, q_fix_s, r_fix_s;

    assign shifted_s = {rem_r, quo_r[MSB]};
    assign trial_s   = shifted_s - {1'b0, dvs_r};

    // Keep the trial difference when it did not go negative, shifting in the quotient bit.
    always_comb begin
        rem_step_s = shifted_s[DATA_W-1:0];
        quo_step_s = {quo_r[DATA_W-2:0], 1'b0};
        if (!trial_s[DATA_W]) begin
            rem_step_s = trial_s[DATA_W-1:0];
            quo_step_s = {quo_r[DATA_W-2:0], 1'b1};
        end else begin
            rem_step_s = shifted_s[DATA_W-1:0];
            quo_step_s = {quo_r[DATA_W-2:0], 1'b0};
        end
    end

    assign q_fix_s = neg_q_r ? neg(quo_r) : quo_r;
    assign r_fix_s = neg_r_r ? neg(rem_r) : rem_r;

    // Divider operand latch on accept, then one restoring step per BUSY cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r   <= CNT_ZERO;
            dvs_r   <= ZERO;
            rem_r   <= ZERO;
            quo_r   <= ZERO;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if (accept_s) begin
            if (b_i == ZERO) begin
                // Zero divisor: final values are known immediately, no sign fix-up.
                quo_r   <= ONES;
                rem_r   <= a_i;
                dvs_r   <= ZERO;
                neg_q_r <= 1'b0;
                neg_r_r <= 1'b0;
            end else begin
                quo_r   <= is_signed_div_s ? mag(a_i) : a_i;
                dvs_r   <= is_signed_div_s ? mag(b_i) : b_i;
                rem_r   <= ZERO;
                neg_q_r <= is_signed_div_s && (a_i[MSB] ^ b_i[MSB]);
                neg_r_r <= is_signed_div_s && a_i[MSB];
                cnt_r   <= CNT_FULL;
            end
        end else if ((state_r == ST_BUSY) && !flush_i) begin
            rem_r <= rem_step_s;
            quo_r <= quo_step_s;
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // HI/LO: divider completion has priority; otherwise MULT/MT under the issue qualifier.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hi_r <= ZERO;
            lo_r <= ZERO;
        end else if (done_wr_s) begin
            hi_r <= r_fix_s;
            lo_r <= q_fix_s;
        end else if (valid_i && !stall_s && !flush_i) begin
            case (op_i)
                OP_MULT, OP_MULTU: begin
                    hi_r <= prod_s[2*DATA_W-1:DATA_W];
                    lo_r <= prod_s[DATA_W-1:0];
                end
                OP_MTHI: hi_r <= a_i;
                OP_MTLO: lo_r <= a_i;
                default: begin
                    hi_r <= hi_r;
                    lo_r <= lo_r;
                end
            endcase
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (DATA_W = 32): directed cases plus
// randomized ops checked against an arithmetic reference model.
module tb_alu_muldiv;

    localparam logic [4:0] OP_NOP = 5'd0,  OP_ADD = 5'd5,  OP_ADDU = 5'd6;
    localparam logic [4:0] OP_SLT = 5'd9,  OP_SLTU = 5'd10, OP_SRA = 5'd13;
    localparam logic [4:0] OP_MULT = 5'd15, OP_MULTU = 5'd16, OP_DIV = 5'd17, OP_DIVU = 5'd18;
    localparam logic [4:0] OP_MFHI = 5'd19, OP_MFLO = 5'd20, OP_MTHI = 5'd21, OP_MTLO = 5'd22;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic [4:0]  op_i = 5'd0;
    logic [31:0] a_i = 32'd0;
    logic [31:0] b_i = 32'd0;
    logic        flush_i = 1'b0;
    logic [31:0] result_o;
    logic        overflow_o;
    logic        stall_o;

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    alu_muldiv #(.DATA_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .flush_i(flush_i),
        .result_o(result_o), .overflow_o(overflow_o), .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference for single-cycle ops, from the arithmetic definitions.
    task automatic ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic o);
        longint s;
        longint lim;
        lim = 64'sd2147483648;
        r = 32'd0;
        o = 1'b0;
        case (op)
            5'd1:  r = a | b;
            5'd2:  r = a & b;
            5'd3:  r = a ^ b;
            5'd4:  r = ~(a | b);
            5'd5, 5'd6: begin
                r = a + b;
                s = longint'($signed(a)) + longint'($signed(b));
                o = (op == 5'd5) && ((s >= lim) || (s < -lim));
            end
            5'd7, 5'd8: begin
                r = a - b;
                s = longint'($signed(a)) - longint'($signed(b));
                o = (op == 5'd7) && ((s >= lim) || (s < -lim));
            end
            5'd9:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd10: r = (a < b) ? 32'd1 : 32'd0;
            5'd11: r = b << a[4:0];
            5'd12: r = b >> a[4:0];
            5'd13: r = $unsigned($signed(b) >>> a[4:0]);
            5'd14: r = b << 16;
            5'd19: r = m_hi;
            5'd20: r = m_lo;
            default: r = 32'd0;
        endcase
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        valid_i = 1'b1;
        op_i = op;
        a_i = a;
        b_i = b;
        @(negedge clk_i);
    endtask

    // Clock the instruction in and update the HI/LO model for MULT/MT ops.
    task automatic commit();
        logic [63:0] p;
        @(posedge clk_i);
        #1;
        case (op_i)
            OP_MULT: begin
                p = longint'($signed(a_i)) * longint'($signed(b_i));
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            OP_MULTU: begin
                p = {32'd0, a_i} * {32'd0, b_i};
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            OP_MTHI: m_hi = a_i;
            OP_MTLO: m_lo = a_i;
            default: ;
        endcase
        valid_i = 1'b0;
    endtask

    task automatic rd_hilo(input logic [31:0] eh, input logic [31:0] el, input string tag);
        drive(OP_MFHI, 32'd0, 32'd0);
        check({tag, "_hi"}, result_o, eh);
        commit();
        drive(OP_MFLO, 32'd0, 32'd0);
        check({tag, "_lo"}, result_o, el);
        commit();
    endtask

    // Issue a divide, measure the stall length, update the model at completion.
    task automatic do_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        int n;
        int sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (op == OP_DIVU) begin
            q = a / b; r = a % b;
        end else begin
            sa = a; sb = b;
            q = sa / sb; r = sa % sb;
        end
        drive(op, a, b);
        n = 0;
        while (stall_o && n < 100) begin
            n++;
            @(posedge clk_i);
            @(negedge clk_i);
        end
        check({tag, "_stall"}, n, (b == 32'd0) ? 32'd1 : 32'd33);
        check({tag, "_res0"}, result_o, 32'd0);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        m_hi = r;
        m_lo = q;
    endtask

    // Start a DIV and flush it in BUSY cycle nb.
    task automatic flush_div(input int nb);
        drive(OP_DIV, 32'hFFFF_FF9C, 32'd7);
        check("flush_acc_stall", stall_o, 32'd1);
        @(posedge clk_i);
        repeat (nb - 1) @(posedge clk_i);
        #1;
        flush_i = 1'b1;
        @(negedge clk_i);
        check("flush_stall", stall_o, 32'd0);
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        valid_i = 1'b0;
    endtask

    initial begin
        logic [31:0] er, a, b;
        logic eo;
        logic [4:0] op;
        int k;

        // Reset state, including outputs forced low with an instruction present.
        valid_i = 1'b1; op_i = OP_ADD; a_i = 32'h7FFF_FFFF; b_i = 32'd1;
        @(negedge clk_i);
        check("rst_result", result_o, 32'd0);
        check("rst_ovf", overflow_o, 32'd0);
        check("rst_stall", stall_o, 32'd0);
        valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        rd_hilo(32'd0, 32'd0, "rst_hilo");

        // Directed single-cycle cases.
        drive(OP_ADD, 32'h7FFF_FFFF, 32'd1);
        check("add_res", result_o, 32'h8000_0000);
        check("add_ovf", overflow_o, 32'd1);
        commit();
        drive(OP_ADDU, 32'h7FFF_FFFF, 32'd1);
        check("addu_ovf", overflow_o, 32'd0);
        commit();
        drive(OP_SRA, 32'd4, 32'h8000_0000);
        check("sra", result_o, 32'hF800_0000);
        commit();
        drive(OP_SLTU, 32'd1, 32'hFFFF_FFFF);
        check("sltu", result_o, 32'd1);
        commit();
        drive(OP_SLT, 32'd1, 32'hFFFF_FFFF);
        check("slt", result_o, 32'd0);
        commit();

        // Random single-cycle ops, including the unused opcodes.
        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 19);
            op = (k < 15) ? 5'(k) : 5'(k + 8);
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) a = {a[31], {31{~a[31]}}};
            if ($urandom_range(0, 3) == 0) b = {b[31], {31{~b[31]}}};
            drive(op, a, b);
            ref_alu(op, a, b, er, eo);
            check("rnd_res", result_o, er);
            check("rnd_ovf", overflow_o, {31'd0, eo});
            check("rnd_stall", stall_o, 32'd0);
            commit();
        end

        // Multiplier, directed.
        drive(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        check("mult_res0", result_o, 32'd0);
        check("mult_stall", stall_o, 32'd0);
        commit();
        rd_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
        drive(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
        commit();
        rd_hilo(32'd2, 32'hFFFF_FFFA, "multu");

        // Random MULT/MULTU/MTHI/MTLO followed by read-back.
        for (int i = 0; i < 30; i++) begin
            k = $urandom_range(0, 3);
            op = (k == 0) ? OP_MULT : (k == 1) ? OP_MULTU : (k == 2) ? OP_MTHI : OP_MTLO;
            drive(op, $urandom, $urandom);
            check("rnd_md_res0", result_o, 32'd0);
            commit();
            rd_hilo(m_hi, m_lo, "rnd_md");
        end

        // Divider, directed.
        do_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        rd_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
        do_div(OP_DIVU, 32'd100, 32'd7, "divu_100_7");
        rd_hilo(32'd2, 32'd14, "divu_100_7");
        do_div(OP_DIVU, 32'd5, 32'd0, "divu_5_0");
        rd_hilo(32'd5, 32'hFFFF_FFFF, "divu_5_0");

        // Random divides, some with small or zero divisors.
        for (int i = 0; i < 10; i++) begin
            op = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_DIVU;
            a = $urandom;
            k = $urandom_range(0, 3);
            b = (k == 0) ? 32'd0 : (k == 1) ? 32'($urandom_range(1, 20)) : $urandom;
            if (op == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            do_div(op, a, b, "rnd_div");
            rd_hilo(m_hi, m_lo, "rnd_div");
        end

        // Flush in BUSY cycle 10: HI/LO untouched.
        drive(OP_MTHI, 32'h1111_1111, 32'd0);
        commit();
        drive(OP_MTLO, 32'h1111_1111, 32'd0);
        commit();
        flush_div(10);
        rd_hilo(32'h1111_1111, 32'h1111_1111, "flush_busy");

        // Flush again, then a back-to-back DIVU completes correctly.
        flush_div(10);
        do_div(OP_DIVU, 32'd1000, 32'd33, "b2b_divu");
        rd_hilo(32'd10, 32'd30, "b2b_divu");

        // Flush during DONE suppresses the write.
        drive(OP_DIVU, 32'd9, 32'd0);
        check("done_flush_acc", stall_o, 32'd1);
        @(posedge clk_i);
        #1;
        flush_i = 1'b1;
        @(negedge clk_i);
        check("done_flush_stall", stall_o, 32'd0);
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        rd_hilo(32'd10, 32'd30, "done_flush");

        // Asynchronous reset between edges in the middle of a divide.
        drive(OP_DIVU, 32'hDEAD_BEEF, 32'd5);
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_stall", stall_o, 32'd0);
        check("arst_result", result_o, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        rd_hilo(32'd0, 32'd0, "arst_hilo");
        drive(OP_MTLO, 32'hA5A5_A5A5, 32'd0);
        commit();
        drive(OP_MFLO, 32'd0, 32'd0);
        check("mtlo_mflo", result_o, 32'hA5A5_A5A5);
        commit();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
